bypass_ctrl: RTL and testbench
==============================

BYPASS_CTRL -- requirements
Module: bypass_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clock clk.
REQ-003 en  input  1  pipeline advance; 0 freezes all tracked state.
REQ-004 flush  input  1  discard all in-flight writers (branch/interrupt).
REQ-005 gpr_a, gpr_b, gpr_c  input  5 each  source register numbers of the instruction in decode.
REQ-006 read_gpr_a, read_gpr_b, read_gpr_c  input  1 each  corresponding source operand is used.
REQ-007 gpr_dest_alu, gpr_dest_mem  input  5 each  destination register numbers of the decode instruction.
REQ-008 write_gpr_dest_alu, write_gpr_dest_mem  input  1 each  ALU / load-result destination is written.
REQ-009 sel_a, sel_b, sel_c  output  2 each  operand source: 0 register file, 1 EX result, 2 LS result, 3 WB result.
REQ-010 stall  output  1  decode must hold; operand not yet producible.

Function
REQ-011 The block SHALL hold a 3-entry in-flight table, one entry each for EX, LS and WB; each entry holds alu_v, alu_reg, mem_v and mem_reg.
REQ-012 On a rising edge with en=1, flush=0 and stall=0, the block SHALL shift LS->WB and EX->LS and load EX from the decode destinations.
REQ-013 On a rising edge with en=1, flush=0 and stall=1, the block SHALL shift LS->WB and EX->LS and load EX with a bubble (all valids 0).
REQ-014 With en=0 and flush=0, the block SHALL leave the table unchanged.
REQ-015 flush=1 SHALL clear all valids on the next edge regardless of en, and SHALL force stall=0 and sel_*=0 combinationally in the same cycle.
REQ-016 sel_x and stall SHALL be combinational from current table and decode inputs (zero latency); an operand with read_gpr_x=0 SHALL give sel_x=0 and no stall.
REQ-017 Operand matching SHALL search youngest first (EX, then LS, then WB); only the youngest matching entry counts.
REQ-018 Within one entry, when both alu and mem tags match, the mem tag SHALL win.
REQ-019 An ALU tag match in EX, LS or WB SHALL select 1, 2 or 3 respectively with no stall.
REQ-020 A mem tag match in EX or LS SHALL assert stall (load-use) with sel_x=0.
REQ-021 A mem tag match in WB SHALL select 3 with no stall.
REQ-022 stall SHALL be the OR over the three operands; sel_* SHALL be valid independently of stall.
REQ-023 Register 0 SHALL be tracked like any other register; all 32 GPRs are forwardable.
REQ-024 A decode instruction reading and writing the same register SHALL match only older entries, never itself.

Reset
REQ-025 reset SHALL clear every valid bit asynchronously; thereafter sel_*=0 and stall=0 until a writer is loaded.
REQ-026 Deasserting reset mid-operation SHALL leave no residual stall; the first edge after release SHALL follow REQ-012 to REQ-014.

Configuration
REQ-027 With macro BYPASS_WB_FORWARD_EN defined, WB matches SHALL forward per REQ-019 and REQ-021 (sel=3).
REQ-028 Without BYPASS_WB_FORWARD_EN, any WB-only match SHALL assert stall with sel_x=0 (register-file write-before-read assumed absent).
REQ-029 Without BYPASS_WB_FORWARD_EN, sel value 3 SHALL never be driven.

Verification
REQ-030 The bench SHALL cover ALU write r5, then next cycle read_gpr_a r5 -> sel_a=1, stall=0; one cycle later -> sel_a=2; two later -> sel_a=3 (macro on).
REQ-031 The bench SHALL cover load r7, then next cycle read_gpr_b r7 -> stall=1 for 2 cycles (EX, LS), then sel_b=3 and stall=0; EX receives a bubble on each stall cycle.
REQ-032 The bench SHALL cover ALU write r3 followed by ALU write r3, then read r3 -> sel=1 (youngest EX entry), not 2.
REQ-033 The bench SHALL cover a load with update (mem r4, alu r4) in EX while decode reads r4 -> stall=1 (mem wins).
REQ-034 The bench SHALL cover a table holding writers to r1, r2 and r3 with flush=1 -> stall=0 and sel=0 same cycle; a read of r1 after the edge -> sel=0.
REQ-035 The bench SHALL cover en=0 for 3 cycles with an ALU r9 writer in LS -> table frozen, sel=2 throughout; reset pulse mid-sequence -> sel=0, stall=0 immediately.

Source files
------------

// File: rtl/bypass_ctrl.sv
// Operand bypass/stall control: EX/LS/WB in-flight writer table feeding combinational sel/stall.
// Define BYPASS_WB_FORWARD_EN to forward WB results (sel=3); otherwise WB matches stall.
module bypass_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       flush,
  input  logic [4:0] gpr_a,
  input  logic [4:0] gpr_b,
  input  logic [4:0] gpr_c,
  input  logic       read_gpr_a,
  input  logic       read_gpr_b,
  input  logic       read_gpr_c,
  input  logic [4:0] gpr_dest_alu,
  input  logic [4:0] gpr_dest_mem,
  input  logic       write_gpr_dest_alu,
  input  logic       write_gpr_dest_mem,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic [1:0] sel_c,
  output logic       stall
);

  typedef struct packed {
    logic       alu_v;
    logic [4:0] alu_reg;
    logic       mem_v;
    logic [4:0] mem_reg;
  } entry_t;

  entry_t ex_q, ls_q, wb_q;
  entry_t ex_d, ls_d, wb_d;
  logic [2:0] res_a, res_b, res_c;

  // Result is {stall, sel}; youngest entry wins, and mem beats alu within an entry.
  function automatic logic [2:0] lookup(input logic rd, input logic [4:0] r,
                                        input entry_t ex, input entry_t ls, input entry_t wb);
    logic [2:0] res;
    res = 3'b000;
    if (rd) begin
      if (ex.mem_v && ex.mem_reg == r)       res = 3'b100;
      else if (ex.alu_v && ex.alu_reg == r)  res = 3'b001;
      else if (ls.mem_v && ls.mem_reg == r)  res = 3'b100;
      else if (ls.alu_v && ls.alu_reg == r)  res = 3'b010;
      else if ((wb.mem_v && wb.mem_reg == r) || (wb.alu_v && wb.alu_reg == r)) begin
`ifdef BYPASS_WB_FORWARD_EN
        res = 3'b011;
`else
        res = 3'b100;
`endif
      end
    end
    return res;
  endfunction

  always_comb begin
    res_a = lookup(read_gpr_a, gpr_a, ex_q, ls_q, wb_q);
    res_b = lookup(read_gpr_b, gpr_b, ex_q, ls_q, wb_q);
    res_c = lookup(read_gpr_c, gpr_c, ex_q, ls_q, wb_q);
    sel_a = 2'd0;
    sel_b = 2'd0;
    sel_c = 2'd0;
    stall = 1'b0;
    if (!flush) begin
      sel_a = res_a[1:0];
      sel_b = res_b[1:0];
      sel_c = res_c[1:0];
      stall = res_a[2] | res_b[2] | res_c[2];
    end
  end

  // A stalled decode instruction must not enter EX; it is replaced by a bubble.
  always_comb begin
    ex_d = ex_q;
    ls_d = ls_q;
    wb_d = wb_q;
    if (flush) begin
      ex_d = '0;
      ls_d = '0;
      wb_d = '0;
    end else if (en) begin
      wb_d = ls_q;
      ls_d = ex_q;
      if (stall) ex_d = '0;
      else       ex_d = '{alu_v: write_gpr_dest_alu, alu_reg: gpr_dest_alu,
                          mem_v: write_gpr_dest_mem, mem_reg: gpr_dest_mem};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
      ls_q <= '0;
      wb_q <= '0;
    end else begin
      ex_q <= ex_d;
      ls_q <= ls_d;
      wb_q <= wb_d;
    end
  end

endmodule

// File: tb/tb_bypass_ctrl.sv
// Directed bench for bypass_ctrl; expectations follow the BYPASS_WB_FORWARD_EN build setting.
module tb_bypass_ctrl;

  logic       clk = 1'b0;
  logic       reset, en, flush;
  logic [4:0] gpr_a, gpr_b, gpr_c, gpr_dest_alu, gpr_dest_mem;
  logic       read_gpr_a, read_gpr_b, read_gpr_c;
  logic       write_gpr_dest_alu, write_gpr_dest_mem;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       stall;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef BYPASS_WB_FORWARD_EN
  localparam logic [1:0] WB_SEL   = 2'd3;
  localparam logic       WB_STALL = 1'b0;
`else
  localparam logic [1:0] WB_SEL   = 2'd0;
  localparam logic       WB_STALL = 1'b1;
`endif

  bypass_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .gpr_a(gpr_a), .gpr_b(gpr_b), .gpr_c(gpr_c),
    .read_gpr_a(read_gpr_a), .read_gpr_b(read_gpr_b), .read_gpr_c(read_gpr_c),
    .gpr_dest_alu(gpr_dest_alu), .gpr_dest_mem(gpr_dest_mem),
    .write_gpr_dest_alu(write_gpr_dest_alu), .write_gpr_dest_mem(write_gpr_dest_mem),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                         input logic [1:0] ec, input logic es);
    #1;
    chk({tag, ".sel_a"}, sel_a, ea);
    chk({tag, ".sel_b"}, sel_b, eb);
    chk({tag, ".sel_c"}, sel_c, ec);
    chk({tag, ".stall"}, {1'b0, stall}, {1'b0, es});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic va, input logic [4:0] ra, input logic vb, input logic [4:0] rb,
                    input logic vc, input logic [4:0] rc);
    read_gpr_a = va; gpr_a = ra;
    read_gpr_b = vb; gpr_b = rb;
    read_gpr_c = vc; gpr_c = rc;
  endtask

  task automatic wr(input logic va, input logic [4:0] ra, input logic vm, input logic [4:0] rm);
    write_gpr_dest_alu = va; gpr_dest_alu = ra;
    write_gpr_dest_mem = vm; gpr_dest_mem = rm;
  endtask

  task automatic do_flush();
    rd(0, 0, 0, 0, 0, 0);
    wr(0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    rd(1, 0, 1, 5, 1, 31);
    wr(0, 0, 0, 0);
    #12;
    chk_all("reset_held", 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_all("after_reset", 0, 0, 0, 0);

    // ALU r5 ages through EX, LS, WB
    rd(0, 0, 0, 0, 0, 0); wr(1, 5, 0, 0);
    tick();
    rd(1, 5, 0, 0, 0, 0); wr(0, 0, 0, 0);
    chk_all("alu5_ex", 1, 0, 0, 0);
    tick();
    chk_all("alu5_ls", 2, 0, 0, 0);
    tick();
    chk_all("alu5_wb", WB_SEL, 0, 0, WB_STALL);
    tick();
    chk_all("alu5_gone", 0, 0, 0, 0);

    // r0 is forwardable; self read/write only sees older entries
    rd(0, 0, 0, 0, 0, 0); wr(1, 0, 0, 0);
    tick();
    rd(1, 0, 0, 0, 0, 0); wr(1, 6, 0, 0);
    chk_all("r0_ex", 1, 0, 0, 0);
    tick();
    rd(0, 0, 0, 0, 0, 0); wr(0, 0, 0, 0);
    tick();
    rd(1, 6, 0, 0, 0, 0); wr(1, 6, 0, 0);
    chk_all("self_rw_ls", 2, 0, 0, 0);
    tick();
    chk_all("self_rw_ex", 1, 0, 0, 0);

    // load r7 then dependent read; stalled r8 writer must not enter EX
    do_flush();
    wr(0, 0, 1, 7);
    tick();
    rd(0, 0, 1, 7, 1, 8); wr(1, 8, 0, 0);
    chk_all("load_ex", 0, 0, 0, 1);
    tick();
    chk_all("load_ls", 0, 0, 0, 1);
    tick();
    chk_all("load_wb", 0, WB_SEL, 0, WB_STALL);
    rd(0, 0, 0, 0, 0, 0); wr(0, 0, 0, 0);

    // two r3 writers: youngest (EX) wins
    do_flush();
    wr(1, 3, 0, 0);
    tick();
    tick();
    rd(1, 3, 1, 3, 0, 0); wr(0, 0, 0, 0);
    chk_all("youngest_r3", 1, 1, 0, 0);

    // load with update: mem tag beats alu tag in the same entry
    do_flush();
    wr(1, 4, 1, 4);
    tick();
    rd(0, 0, 0, 0, 1, 4); wr(0, 0, 0, 0);
    chk_all("mem_wins", 0, 0, 0, 1);

    // flush kills r1/r2/r3 writers combinationally and on the edge
    do_flush();
    wr(1, 1, 0, 0); tick();
    wr(1, 2, 0, 0); tick();
    wr(1, 3, 0, 0); tick();
    rd(1, 1, 1, 2, 1, 3); wr(0, 0, 0, 0);
    chk_all("pre_flush", WB_SEL, 2, 1, WB_STALL);
    flush = 1'b1;
    chk_all("flush_comb", 0, 0, 0, 0);
    tick();
    flush = 1'b0;
    chk_all("post_flush", 0, 0, 0, 0);

    // freeze with r9 in LS; decode r10 writer must not load during freeze
    rd(0, 0, 0, 0, 0, 0); wr(1, 9, 0, 0);
    tick();
    wr(0, 0, 0, 0);
    tick();
    en = 1'b0;
    rd(1, 9, 0, 0, 0, 0); wr(1, 10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk_all("freeze", 2, 0, 0, 0);
      tick();
    end
    rd(1, 9, 1, 10, 0, 0); wr(0, 0, 0, 0);
    chk_all("freeze_noload", 2, 0, 0, 0);
    #2;
    reset = 1'b1;
    chk_all("reset_mid", 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    en = 1'b1;
    tick();
    chk_all("after_release", 0, 0, 0, 0);
    rd(0, 0, 0, 0, 0, 0); wr(1, 11, 0, 0);
    tick();
    rd(1, 11, 0, 0, 0, 0); wr(0, 0, 0, 0);
    chk_all("resume", 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
